e203_icb_dotp_engine: RTL and testbench

//  ICB master that consumes the weight/image buffers preloaded into the subsys data RAMs.

---
 rtl/e203_icb_dotp_engine.sv | 199 +++++++++++++++++++
 tb/tb_e203_icb_dotp_engine.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/e203_icb_dotp_engine.sv
// ICB master computing a two-lane unsigned 16x16 dot product over LEN word pairs and writing one result word.
// Optional build macro E203_DOTP_SAT_EN: saturate the 32-bit result instead of truncating the accumulator.
//
// state  | meaning
// IDLE   | waiting for start
// RW_CMD | presenting weight read command
// RW_RSP | waiting for weight read data
// RI_CMD | presenting image read command
// RI_RSP | waiting for image read data
// MAC    | accumulate both lane products, advance index
// WR_CMD | presenting result write command
// WR_RSP | waiting for write response
// DONE   | one-cycle completion pulse
module e203_icb_dotp_engine #(
    parameter int AW    = 32,
    parameter int LEN_W = 12,
    parameter int ACC_W = 48
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [AW-1:0]    i_w_base,
    input  logic [AW-1:0]    i_i_base,
    input  logic [AW-1:0]    i_o_addr,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic             o_icb_cmd_valid,
    input  logic             i_icb_cmd_ready,
    output logic [AW-1:0]    o_icb_cmd_addr,
    output logic             o_icb_cmd_read,
    output logic [31:0]      o_icb_cmd_wdata,
    output logic [3:0]       o_icb_cmd_wmask,
    input  logic             i_icb_rsp_valid,
    output logic             o_icb_rsp_ready,
    input  logic [31:0]      i_icb_rsp_rdata,
    input  logic             i_icb_rsp_err
);

    typedef enum logic [3:0] {
        S_IDLE, S_RW_CMD, S_RW_RSP, S_RI_CMD, S_RI_RSP,
        S_MAC, S_WR_CMD, S_WR_RSP, S_DONE
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [AW-1:0]      r_w_base, r_i_base, r_o_addr;
    logic [LEN_W-1:0]   r_len, r_idx;
    logic [ACC_W-1:0]   r_acc;
    logic [31:0]        r_wword, r_iword;
    logic               r_err, r_busy, r_done, r_rsp_ready;
    logic               r_cmd_valid, r_cmd_read;
    logic [AW-1:0]      r_cmd_addr;
    logic [31:0]        r_cmd_wdata;
    logic [3:0]         r_cmd_wmask;

    logic               w_start_acc, w_cmd_fire, w_rsp_fire, w_err_nxt;
    logic [AW-1:0]      w_w_base_nxt, w_i_base_nxt, w_o_addr_nxt, w_addr_off;
    logic [LEN_W-1:0]   w_len_nxt, w_idx_nxt, w_idx_inc;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic [31:0]        w_p0, w_p1, w_result;
    logic [32:0]        w_lane_sum;
    logic               w_cmd_valid_nxt, w_cmd_read_nxt;
    logic [AW-1:0]      w_cmd_addr_nxt;
    logic [31:0]        w_cmd_wdata_nxt;
    logic [3:0]         w_cmd_wmask_nxt;

    assign w_start_acc = (r_state == S_IDLE) && i_start;
    assign w_cmd_fire  = r_cmd_valid && i_icb_cmd_ready;
    assign w_rsp_fire  = r_rsp_ready && i_icb_rsp_valid;
    assign w_idx_inc   = r_idx + LEN_W'(1);

    assign w_p0       = 32'(r_wword[15:0]) * 32'(r_iword[15:0]);
    assign w_p1       = 32'(r_wword[31:16]) * 32'(r_iword[31:16]);
    assign w_lane_sum = 33'(w_p0) + 33'(w_p1);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_state_nxt = (i_len != '0) ? S_RW_CMD : S_WR_CMD;
            S_RW_CMD: if (w_cmd_fire) w_state_nxt = S_RW_RSP;
            S_RW_RSP: if (w_rsp_fire) w_state_nxt = i_icb_rsp_err ? S_DONE : S_RI_CMD;
            S_RI_CMD: if (w_cmd_fire) w_state_nxt = S_RI_RSP;
            S_RI_RSP: if (w_rsp_fire) w_state_nxt = i_icb_rsp_err ? S_DONE : S_MAC;
            S_MAC:    w_state_nxt = (w_idx_inc == r_len) ? S_WR_CMD : S_RW_CMD;
            S_WR_CMD: if (w_cmd_fire) w_state_nxt = S_WR_RSP;
            S_WR_RSP: if (w_rsp_fire) w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_w_base_nxt = w_start_acc ? i_w_base : r_w_base;
        w_i_base_nxt = w_start_acc ? i_i_base : r_i_base;
        w_o_addr_nxt = w_start_acc ? i_o_addr : r_o_addr;
        w_len_nxt    = w_start_acc ? i_len    : r_len;
        w_idx_nxt    = r_idx;
        w_acc_nxt    = r_acc;
        if (w_start_acc) begin
            w_idx_nxt = '0;
            w_acc_nxt = '0;
        end else if (r_state == S_MAC) begin
            w_idx_nxt = w_idx_inc;
            w_acc_nxt = r_acc + ACC_W'(w_lane_sum);
        end
        w_err_nxt = w_start_acc ? 1'b0 : (r_err || (w_rsp_fire && i_icb_rsp_err));
    end

    // Command fields are computed from next-cycle values so they are registered on state entry.
    assign w_addr_off = AW'({w_idx_nxt, 2'b00});

`ifdef E203_DOTP_SAT_EN
    assign w_result = (|w_acc_nxt[ACC_W-1:32]) ? 32'hFFFF_FFFF : w_acc_nxt[31:0];
`else
    assign w_result = w_acc_nxt[31:0];
`endif

    always_comb begin
        w_cmd_valid_nxt = 1'b0;
        w_cmd_read_nxt  = 1'b0;
        w_cmd_addr_nxt  = '0;
        w_cmd_wdata_nxt = '0;
        w_cmd_wmask_nxt = '0;
        case (w_state_nxt)
            S_RW_CMD: begin
                w_cmd_valid_nxt = 1'b1;
                w_cmd_read_nxt  = 1'b1;
                w_cmd_addr_nxt  = w_w_base_nxt + w_addr_off;
            end
            S_RI_CMD: begin
                w_cmd_valid_nxt = 1'b1;
                w_cmd_read_nxt  = 1'b1;
                w_cmd_addr_nxt  = w_i_base_nxt + w_addr_off;
            end
            S_WR_CMD: begin
                w_cmd_valid_nxt = 1'b1;
                w_cmd_addr_nxt  = w_o_addr_nxt;
                w_cmd_wdata_nxt = w_result;
                w_cmd_wmask_nxt = 4'hF;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_w_base    <= '0;
            r_i_base    <= '0;
            r_o_addr    <= '0;
            r_len       <= '0;
            r_idx       <= '0;
            r_acc       <= '0;
            r_wword     <= '0;
            r_iword     <= '0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rsp_ready <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_cmd_read  <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_wdata <= '0;
            r_cmd_wmask <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_w_base    <= w_w_base_nxt;
            r_i_base    <= w_i_base_nxt;
            r_o_addr    <= w_o_addr_nxt;
            r_len       <= w_len_nxt;
            r_idx       <= w_idx_nxt;
            r_acc       <= w_acc_nxt;
            if (r_state == S_RW_RSP && w_rsp_fire) r_wword <= i_icb_rsp_rdata;
            if (r_state == S_RI_RSP && w_rsp_fire) r_iword <= i_icb_rsp_rdata;
            r_err       <= w_err_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= (w_state_nxt == S_DONE);
            r_rsp_ready <= (w_state_nxt == S_RW_RSP) || (w_state_nxt == S_RI_RSP) ||
                           (w_state_nxt == S_WR_RSP);
            r_cmd_valid <= w_cmd_valid_nxt;
            r_cmd_read  <= w_cmd_read_nxt;
            r_cmd_addr  <= w_cmd_addr_nxt;
            r_cmd_wdata <= w_cmd_wdata_nxt;
            r_cmd_wmask <= w_cmd_wmask_nxt;
        end
    end

    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_err           = r_err;
    assign o_icb_cmd_valid = r_cmd_valid;
    assign o_icb_cmd_addr  = r_cmd_addr;
    assign o_icb_cmd_read  = r_cmd_read;
    assign o_icb_cmd_wdata = r_cmd_wdata;
    assign o_icb_cmd_wmask = r_cmd_wmask;
    assign o_icb_rsp_ready = r_rsp_ready;

endmodule

// File: tb/tb_e203_icb_dotp_engine.sv
// Bench for e203_icb_dotp_engine: ICB RAM slave with optional stalls/error injection, write scoreboard.
module tb_e203_icb_dotp_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] w_base = '0, i_base = '0, o_addr = '0;
    logic [11:0] len = '0;
    logic        busy, done, err;
    logic        cmd_valid, cmd_read, rsp_ready;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wmask;
    logic        s_cmd_ready = 1'b0, s_rsp_valid = 1'b0, s_rsp_err = 1'b0;
    logic [31:0] s_rsp_rdata = '0;

    always #5 clk = ~clk;

    e203_icb_dotp_engine dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .i_w_base(w_base), .i_i_base(i_base), .i_o_addr(o_addr), .i_len(len),
        .o_busy(busy), .o_done(done), .o_err(err),
        .o_icb_cmd_valid(cmd_valid), .i_icb_cmd_ready(s_cmd_ready),
        .o_icb_cmd_addr(cmd_addr), .o_icb_cmd_read(cmd_read),
        .o_icb_cmd_wdata(cmd_wdata), .o_icb_cmd_wmask(cmd_wmask),
        .i_icb_rsp_valid(s_rsp_valid), .o_icb_rsp_ready(rsp_ready),
        .i_icb_rsp_rdata(s_rsp_rdata), .i_icb_rsp_err(s_rsp_err)
    );

    // Memory and control knobs are owned by the stimulus block; the slave only reads them.
    logic [31:0] mem [0:255];
    bit          stall_en = 1'b0;
    bit          err_en = 1'b0;
    logic [31:0] err_addr = '0;

    int          wr_cnt = 0, rd_cnt = 0, unstable_cnt = 0;
    logic [31:0] wr_addr_log [0:15];
    logic [31:0] wr_data_log [0:15];
    logic [3:0]  wr_mask_log [0:15];

    bit          cmd_fire_p = 1'b0, rsp_fire_p = 1'b0, rsp_pend = 1'b0, hold_v = 1'b0;
    int          rsp_wait = 0, rdy_wait = 0;
    logic [31:0] pend_data = '0, hold_addr = '0, hold_wdata = '0;
    logic        pend_err = 1'b0, hold_read = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            s_cmd_ready = 1'b0; s_rsp_valid = 1'b0; s_rsp_err = 1'b0; s_rsp_rdata = '0;
            cmd_fire_p = 1'b0; rsp_fire_p = 1'b0; rsp_pend = 1'b0; hold_v = 1'b0;
            rsp_wait = 0; rdy_wait = 0;
        end else begin
            if (rsp_fire_p) begin
                s_rsp_valid = 1'b0; s_rsp_err = 1'b0;
            end
            if (cmd_fire_p) begin
                rsp_pend = 1'b1; hold_v = 1'b0;
                rsp_wait = stall_en ? int'($urandom_range(0, 7)) : 0;
                rdy_wait = stall_en ? int'($urandom_range(0, 7)) : 0;
            end
            if (rsp_pend) begin
                if (rsp_wait == 0) begin
                    s_rsp_valid = 1'b1; s_rsp_rdata = pend_data; s_rsp_err = pend_err;
                    rsp_pend = 1'b0;
                end else begin
                    rsp_wait--;
                end
            end
            if (cmd_valid) begin
                if (hold_v && (cmd_addr !== hold_addr || cmd_read !== hold_read ||
                               cmd_wdata !== hold_wdata))
                    unstable_cnt++;
                hold_v = 1'b1; hold_addr = cmd_addr; hold_read = cmd_read; hold_wdata = cmd_wdata;
                if (rdy_wait == 0) s_cmd_ready = 1'b1;
                else begin
                    s_cmd_ready = 1'b0; rdy_wait--;
                end
            end else begin
                s_cmd_ready = !stall_en;
            end
            cmd_fire_p = cmd_valid && s_cmd_ready;
            rsp_fire_p = s_rsp_valid && rsp_ready;
            if (cmd_fire_p) begin
                pend_err = err_en && (cmd_addr == err_addr);
                if (cmd_read) begin
                    rd_cnt++;
                    pend_data = mem[cmd_addr[9:2]];
                end else begin
                    wr_addr_log[wr_cnt % 16] = cmd_addr;
                    wr_data_log[wr_cnt % 16] = cmd_wdata;
                    wr_mask_log[wr_cnt % 16] = cmd_wmask;
                    wr_cnt++;
                    pend_data = '0;
                end
            end
        end
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    int n_pass = 0, n_total = 0, n_fail = 0;
    int wr_seen = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [31:0] wb, input logic [31:0] ib, input logic [31:0] ob,
                          input logic [11:0] n, input bit hammer,
                          output int cyc, output bit timed_out, output int busy_bad);
        @(negedge clk);
        w_base = wb; i_base = ib; o_addr = ob; len = n; start = 1'b1;
        cyc = 0; timed_out = 1'b1; busy_bad = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (busy !== 1'b1) busy_bad++;
            if (done === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
            if (hammer) begin
                start = 1'($urandom_range(0, 1));
                w_base = $urandom; i_base = $urandom; o_addr = $urandom;
                len = 12'($urandom);
            end
        end
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_wr_count"}, 64'(wr_cnt - wr_seen), 64'(exp_q.size()));
        while (exp_q.size() > 0 && wr_seen < wr_cnt) begin
            exp_t e;
            e = exp_q.pop_front();
            chk({tag, "_wr_addr"}, 64'(wr_addr_log[wr_seen % 16]), 64'(e.addr));
            chk({tag, "_wr_data"}, 64'(wr_data_log[wr_seen % 16]), 64'(e.data));
            chk({tag, "_wr_mask"}, 64'(wr_mask_log[wr_seen % 16]), 64'(4'hF));
            wr_seen++;
        end
        exp_q.delete();
        wr_seen = wr_cnt;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc, bb, rd0, un0;
        bit  to;
        logic [31:0] exp3;

        for (int a = 0; a < 256; a++) mem[a] = '0;
        mem[64]  = 32'h005A_00CD; mem[128] = 32'h00A1_0031;
        mem[65]  = 32'h00D9_00B7; mem[129] = 32'h00B6_0009;
        mem[96]  = 32'hFFFF_FFFF; mem[160] = 32'hFFFF_FFFF;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_cmd_valid", cmd_valid, 1'b0);
        chk("rst_rsp_ready", rsp_ready, 1'b0);
        chk("rst_cmd_fields", {cmd_addr, cmd_wdata}, 64'd0);

        // single pair
        exp_q.push_back('{32'h300, 32'h0000_5FD7});
        run_op(32'h100, 32'h200, 32'h300, 12'd1, 1'b0, cyc, to, bb);
        chk("t1_timeout", to, 1'b0);
        chk("t1_cycles", cyc, 8);
        chk("t1_busy_during", bb, 0);
        chk("t1_err", err, 1'b0);
        @(negedge clk);
        chk("t1_done_pulse", done, 1'b0);
        chk("t1_busy_after", busy, 1'b0);
        check_writes("t1");

        // two pairs
        exp_q.push_back('{32'h304, 32'h0001_008C});
        run_op(32'h100, 32'h200, 32'h304, 12'd2, 1'b0, cyc, to, bb);
        chk("t2_timeout", to, 1'b0);
        chk("t2_cycles", cyc, 13);
        check_writes("t2");

        // lane overflow past 32 bits
`ifdef E203_DOTP_SAT_EN
        exp3 = 32'hFFFF_FFFF;
`else
        exp3 = 32'hFFFC_0002;
`endif
        exp_q.push_back('{32'h308, exp3});
        run_op(32'h180, 32'h280, 32'h308, 12'd1, 1'b0, cyc, to, bb);
        chk("t3_timeout", to, 1'b0);
        chk("t3_cycles", cyc, 8);
        check_writes("t3");

        // len = 0
        rd0 = rd_cnt;
        exp_q.push_back('{32'h30C, 32'h0});
        run_op(32'h180, 32'h280, 32'h30C, 12'd0, 1'b0, cyc, to, bb);
        chk("t4_timeout", to, 1'b0);
        chk("t4_cycles", cyc, 3);
        chk("t4_reads", rd_cnt - rd0, 0);
        check_writes("t4");

        // random stalls with start/config hammering while busy
        stall_en = 1'b1;
        rd0 = rd_cnt; un0 = unstable_cnt;
        exp_q.push_back('{32'h310, 32'h0001_008C});
        run_op(32'h100, 32'h200, 32'h310, 12'd2, 1'b1, cyc, to, bb);
        stall_en = 1'b0;
        chk("t5_timeout", to, 1'b0);
        chk("t5_busy_during", bb, 0);
        chk("t5_reads", rd_cnt - rd0, 4);
        chk("t5_unstable", unstable_cnt - un0, 0);
        chk("t5_err", err, 1'b0);
        repeat (3) @(negedge clk);
        chk("t5_idle_after", busy, 1'b0);
        check_writes("t5");

        // error on second image read
        err_en = 1'b1; err_addr = 32'h204;
        run_op(32'h100, 32'h200, 32'h314, 12'd2, 1'b0, cyc, to, bb);
        chk("t6_timeout", to, 1'b0);
        chk("t6_err_with_done", err, 1'b1);
        @(negedge clk);
        chk("t6_err_held", err, 1'b1);
        err_en = 1'b0;
        repeat (2) @(negedge clk);
        check_writes("t6");

        // restart clears err, then reset mid-run
        w_base = 32'h100; i_base = 32'h200; o_addr = 32'h318; len = 12'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t6_err_cleared", err, 1'b0);
        chk("t6_busy_started", busy, 1'b1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_cmd_valid", cmd_valid, 1'b0);
        chk("t6_rst_rsp_ready", rsp_ready, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_writes("t6_rst");

        // recovery after reset
        exp_q.push_back('{32'h31C, 32'h0000_5FD7});
        run_op(32'h100, 32'h200, 32'h31C, 12'd1, 1'b0, cyc, to, bb);
        chk("t7_timeout", to, 1'b0);
        chk("t7_cycles", cyc, 8);
        check_writes("t7");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
